// File: rtl/surfturf_cmd_serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : surfturf_cmd_serializer_pkg
// Purpose  : Shared command-word layout for the SURF-link command serializer.
//            The RACKBUS_* macros carry the same names and values as the ones
//            in rackbus.vh, which the SURF-side decoder also uses. They are
//            guarded so that whichever definition is seen first is kept.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================

`ifndef RACKBUS_RUNCMD_BITS
`define RACKBUS_RUNCMD_BITS 2
`endif
`ifndef RACKBUS_TRIG_BITS
`define RACKBUS_TRIG_BITS 15
`endif
`ifndef RACKBUS_CMD_PARITY
`define RACKBUS_CMD_PARITY 31
`endif
`ifndef RACKBUS_CMD_RUNCMD_LSB
`define RACKBUS_CMD_RUNCMD_LSB 29
`endif
`ifndef RACKBUS_CMD_TRIGV
`define RACKBUS_CMD_TRIGV 28
`endif
`ifndef RACKBUS_CMD_TRIG_LSB
`define RACKBUS_CMD_TRIG_LSB 13
`endif
`ifndef RACKBUS_CMD_FWV
`define RACKBUS_CMD_FWV 12
`endif
`ifndef RACKBUS_CMD_MARK_LSB
`define RACKBUS_CMD_MARK_LSB 10
`endif
`ifndef RACKBUS_CMD_SEQ_LSB
`define RACKBUS_CMD_SEQ_LSB 8
`endif
`ifndef RACKBUS_CMD_FW_LSB
`define RACKBUS_CMD_FW_LSB 0
`endif

package surfturf_cmd_serializer_pkg;

    localparam int c_word_bits = 32;
    localparam int c_seq_bits  = 2;
    localparam int c_mark_bits = 2;
    localparam int c_fw_bits   = 8;

    // Odd parity: the returned bit makes the total count of ones in the
    // full word odd, so an all-zero body still yields a nonzero word.
    function automatic logic odd_parity(input logic [c_word_bits-2:0] body);
        return ~(^body);
    endfunction

endpackage

`default_nettype wire

// File: rtl/surfturf_cmd_serializer.sv
`default_nettype none
// ============================================================================
// Module   : surfturf_cmd_serializer
// Purpose  : Merges at most one item per frame from the fwupdate, mark,
//            run-command and trigger streams into a 32-bit command word with
//            odd parity, and shifts it out MSB-first on a single serial line.
// Ports    :
//   sysclk_i        in   system clock
//   sysclk_rstn_i   in   asynchronous active-low reset
//   fw_tdata/tvalid in   fwupdate byte stream;     fw_tready     out pulse
//   fw_mark_i       in   pending firmware mark levels
//   fw_marked_o     out  pulse when the marks go into a word
//   runcmd_tdata/tvalid  run command stream;       runcmd_tready out pulse
//   trig_tdata/tvalid    trigger stream;           trig_tready   out pulse
//   cmd_o           out  serial command bit
//   cmd_frame_o     out  high while bit 31 of a word is on cmd_o
// Revision : 1.0 - initial release
// ============================================================================

module surfturf_cmd_serializer
    import surfturf_cmd_serializer_pkg::*;
#(
    parameter int FRAME_BITS = 32
) (
    input  logic                            sysclk_i,
    input  logic                            sysclk_rstn_i,
    input  logic [7:0]                      fw_tdata,
    input  logic                            fw_tvalid,
    output logic                            fw_tready,
    input  logic [1:0]                      fw_mark_i,
    output logic                            fw_marked_o,
    input  logic [`RACKBUS_RUNCMD_BITS-1:0] runcmd_tdata,
    input  logic                            runcmd_tvalid,
    output logic                            runcmd_tready,
    input  logic [`RACKBUS_TRIG_BITS-1:0]   trig_tdata,
    input  logic                            trig_tvalid,
    output logic                            trig_tready,
    output logic                            cmd_o,
    output logic                            cmd_frame_o
);

    localparam int                  c_cnt_w    = $clog2(FRAME_BITS);
    // LOAD is the last count of the frame; the pulses are decoded one earlier
    // so they are registered and land exactly on the LOAD cycle.
    localparam logic [c_cnt_w-1:0]  c_cnt_load = c_cnt_w'(FRAME_BITS - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_pre  = c_cnt_w'(FRAME_BITS - 2);

    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_word_bits-1:0] r_shift;
    logic [c_seq_bits-1:0]  r_seq;
    logic                   r_tready;
    logic                   r_marked;
    logic                   r_frame;

    logic [c_word_bits-2:0] w_body;
    logic [c_word_bits-1:0] w_word;
    logic                   w_load;

    assign w_load = (r_cnt == c_cnt_load);

    // Word assembly. Items only contribute when the handshake completes; the
    // first LOAD after reset has tready low, so it always carries an empty
    // word rather than an item the upstream would never see consumed.
    always_comb begin
        w_body = '0;
        if (r_tready && runcmd_tvalid) begin
            w_body[`RACKBUS_CMD_RUNCMD_LSB +: `RACKBUS_RUNCMD_BITS] = runcmd_tdata;
        end
        if (r_tready && trig_tvalid) begin
            w_body[`RACKBUS_CMD_TRIGV]                          = 1'b1;
            w_body[`RACKBUS_CMD_TRIG_LSB +: `RACKBUS_TRIG_BITS] = trig_tdata;
        end
        if (r_tready && fw_tvalid) begin
            w_body[`RACKBUS_CMD_FWV]                  = 1'b1;
            w_body[`RACKBUS_CMD_FW_LSB +: c_fw_bits]  = fw_tdata;
        end
        if (r_marked) begin
            w_body[`RACKBUS_CMD_MARK_LSB +: c_mark_bits] = fw_mark_i;
        end
        w_body[`RACKBUS_CMD_SEQ_LSB +: c_seq_bits] = r_seq;
    end

    assign w_word = {odd_parity(w_body), w_body};

    // Reset parks the counter on LOAD so the first cycle after release
    // starts a fresh frame; any partially sent word is simply discarded.
    always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
        if (!sysclk_rstn_i) begin
            r_cnt    <= c_cnt_load;
            r_shift  <= '0;
            r_seq    <= '0;
            r_tready <= 1'b0;
            r_marked <= 1'b0;
            r_frame  <= 1'b0;
        end else begin
            r_cnt    <= w_load ? '0 : r_cnt + c_cnt_w'(1);
            r_tready <= (r_cnt == c_cnt_pre);
            r_marked <= (r_cnt == c_cnt_pre) && (fw_mark_i != '0);
            r_frame  <= w_load;
            if (w_load) begin
                r_shift <= w_word;
                r_seq   <= r_seq + c_seq_bits'(1);
            end else begin
                r_shift <= {r_shift[c_word_bits-2:0], 1'b0};
            end
        end
    end

    assign fw_tready     = r_tready;
    assign runcmd_tready = r_tready;
    assign trig_tready   = r_tready;
    assign fw_marked_o   = r_marked;
    assign cmd_o         = r_shift[c_word_bits-1];
    assign cmd_frame_o   = r_frame;

endmodule

`default_nettype wire

// File: tb/tb_surfturf_cmd_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_surfturf_cmd_serializer
// Purpose  : Self-checking bench for surfturf_cmd_serializer. Expected words
//            are queued as stimulus is applied; a monitor reassembles the
//            serial stream and compares each finished word.
// Revision : 1.0 - initial release
// ============================================================================

module tb_surfturf_cmd_serializer;

    logic        sysclk_i;
    logic        sysclk_rstn_i;
    logic [7:0]  fw_tdata;
    logic        fw_tvalid;
    logic        fw_tready;
    logic [1:0]  fw_mark_i;
    logic        fw_marked_o;
    logic [1:0]  runcmd_tdata;
    logic        runcmd_tvalid;
    logic        runcmd_tready;
    logic [14:0] trig_tdata;
    logic        trig_tvalid;
    logic        trig_tready;
    logic        cmd_o;
    logic        cmd_frame_o;

    int checks   = 0;
    int failures = 0;
    int next_frame = 0;
    int tot_fw = 0, tot_run = 0, tot_trig = 0;

    logic [31:0] exp_q [$];

    surfturf_cmd_serializer #(.FRAME_BITS(32)) u_dut (
        .sysclk_i      (sysclk_i),
        .sysclk_rstn_i (sysclk_rstn_i),
        .fw_tdata      (fw_tdata),
        .fw_tvalid     (fw_tvalid),
        .fw_tready     (fw_tready),
        .fw_mark_i     (fw_mark_i),
        .fw_marked_o   (fw_marked_o),
        .runcmd_tdata  (runcmd_tdata),
        .runcmd_tvalid (runcmd_tvalid),
        .runcmd_tready (runcmd_tready),
        .trig_tdata    (trig_tdata),
        .trig_tvalid   (trig_tvalid),
        .trig_tready   (trig_tready),
        .cmd_o         (cmd_o),
        .cmd_frame_o   (cmd_frame_o)
    );

    initial sysclk_i = 1'b0;
    always #5 sysclk_i = ~sysclk_i;

    // Independent word model built from the documented field layout.
    function automatic logic [31:0] exp_word(
        input logic [1:0]  seq,
        input logic        runv, input logic [1:0]  run,
        input logic        trigv, input logic [14:0] trig,
        input logic        fwv, input logic [7:0]  fw,
        input logic [1:0]  mark
    );
        logic [30:0] b;
        b = '0;
        if (runv)  b[30:29] = run;
        if (trigv) begin b[28] = 1'b1; b[27:13] = trig; end
        if (fwv)   begin b[12] = 1'b1; b[7:0]   = fw;   end
        b[11:10] = mark;
        b[9:8]   = seq;
        return {~(^b), b};
    endfunction

    // Monitor: rebuilds words from cmd_o, framed by cmd_frame_o.
    initial begin
        logic [31:0] acc;
        logic [31:0] want;
        int          n;
        acc = '0;
        n   = 0;
        forever begin
            @(negedge sysclk_i);
            if (!sysclk_rstn_i) begin
                n = 0;
            end else begin
                if (cmd_frame_o) begin
                    acc = {31'b0, cmd_o};
                    n   = 1;
                end else if (n != 0) begin
                    acc = {acc[30:0], cmd_o};
                    n   = n + 1;
                end
                if (n == 32) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL word_unexpected got=%h required=none", acc);
                    end else begin
                        want = exp_q.pop_front();
                        if (acc !== want) begin
                            failures++;
                            $display("FAIL word got=%h required=%h", acc, want);
                        end
                    end
                    checks++;
                    if ((^acc) !== 1'b1) begin
                        failures++;
                        $display("FAIL word_parity got=%h required=odd_ones", acc);
                    end
                    n = 0;
                end
            end
        end
    end

    // Presents one frame's items, runs the 32-cycle window that ends on the
    // LOAD edge, and checks the pulse positions inside that window.
    task automatic drive_frame(
        input logic fwv, input logic [7:0] fw, input logic [1:0] mark,
        input logic runv, input logic [1:0] run,
        input logic trigv, input logic [14:0] trig,
        input logic [31:0] expw
    );
        logic [31:0] v_fw, v_run, v_trig, v_mk, v_fr, want_mk;
        fw_tdata = fw;     fw_tvalid = fwv;   fw_mark_i = mark;
        runcmd_tdata = run; runcmd_tvalid = runv;
        trig_tdata = trig; trig_tvalid = trigv;
        exp_q.push_back(expw);
        next_frame++;
        v_fw = '0; v_run = '0; v_trig = '0; v_mk = '0; v_fr = '0;
        for (int c = 0; c < 32; c++) begin
            @(negedge sysclk_i);
            v_fw[c]   = fw_tready;
            v_run[c]  = runcmd_tready;
            v_trig[c] = trig_tready;
            v_mk[c]   = fw_marked_o;
            v_fr[c]   = cmd_frame_o;
            if (fw_tready)     tot_fw++;
            if (runcmd_tready) tot_run++;
            if (trig_tready)   tot_trig++;
            @(posedge sysclk_i);
        end
        #1;
        fw_tvalid = 1'b0; runcmd_tvalid = 1'b0; trig_tvalid = 1'b0; fw_mark_i = 2'b00;
        want_mk = (mark != 2'b00) ? 32'h8000_0000 : 32'h0;
        checks++;
        if (v_fw !== 32'h8000_0000) begin
            failures++; $display("FAIL fw_tready_pulse got=%h required=80000000", v_fw);
        end
        checks++;
        if (v_run !== 32'h8000_0000) begin
            failures++; $display("FAIL runcmd_tready_pulse got=%h required=80000000", v_run);
        end
        checks++;
        if (v_trig !== 32'h8000_0000) begin
            failures++; $display("FAIL trig_tready_pulse got=%h required=80000000", v_trig);
        end
        checks++;
        if (v_mk !== want_mk) begin
            failures++; $display("FAIL fw_marked_pulse got=%h required=%h", v_mk, want_mk);
        end
        checks++;
        if (v_fr !== 32'h0000_0001) begin
            failures++; $display("FAIL cmd_frame_pos got=%h required=00000001", v_fr);
        end
    endtask

    task automatic idle_frame();
        drive_frame(1'b0, 8'h00, 2'b00, 1'b0, 2'b00, 1'b0, 15'h0,
                    exp_word(2'(next_frame), 1'b0, 2'b00, 1'b0, 15'h0, 1'b0, 8'h00, 2'b00));
    endtask

    // Releases reset on a falling edge; the next rising edge is LOAD.
    task automatic release_reset();
        sysclk_rstn_i = 1'b1;
        exp_q.push_back(32'h8000_0000);
        next_frame = 1;
        checks++;
        if ({fw_tready, runcmd_tready, trig_tready, fw_marked_o} !== 4'b0000) begin
            failures++;
            $display("FAIL first_load_tready got=%b required=0000",
                     {fw_tready, runcmd_tready, trig_tready, fw_marked_o});
        end
        @(posedge sysclk_i);
        #1;
        checks++;
        if (cmd_frame_o !== 1'b1) begin
            failures++; $display("FAIL load_after_release cmd_frame_o got=%b required=1", cmd_frame_o);
        end
        checks++;
        if (cmd_o !== 1'b1) begin
            failures++; $display("FAIL frame0_bit31 got=%b required=1", cmd_o);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sysclk_i);
        checks++;
        if ({fw_tready, runcmd_tready, trig_tready, fw_marked_o, cmd_o, cmd_frame_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b required=000000",
                     {fw_tready, runcmd_tready, trig_tready, fw_marked_o, cmd_o, cmd_frame_o});
        end
        release_reset();
        drive_frame(1'b0, 8'h00, 2'b00, 1'b0, 2'b00, 1'b0, 15'h0, 32'h0000_0100);
    endtask

    task automatic test_runcmd();
        drive_frame(1'b0, 8'h00, 2'b00, 1'b1, 2'b10, 1'b0, 15'h0, 32'hC000_0200);
    endtask

    task automatic test_trig();
        while ((next_frame % 4) != 0) idle_frame();
        drive_frame(1'b0, 8'h00, 2'b00, 1'b0, 2'b00, 1'b1, 15'h1234, 32'h9246_8000);
    endtask

    task automatic test_fw_mark();
        while ((next_frame % 4) != 3) idle_frame();
        drive_frame(1'b1, 8'hA5, 2'b01, 1'b0, 2'b00, 1'b0, 15'h0, 32'h8000_17A5);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  fw;
        logic [1:0]  mk, run;
        logic [14:0] tr;
        tot_fw = 0; tot_run = 0; tot_trig = 0;
        for (int f = 0; f < 8; f++) begin
            fw  = 8'($urandom);
            mk  = 2'($urandom_range(1, 3));
            run = 2'($urandom);
            tr  = 15'($urandom);
            drive_frame(1'b1, fw, mk, 1'b1, run, 1'b1, tr,
                        exp_word(2'(next_frame), 1'b1, run, 1'b1, tr, 1'b1, fw, mk));
        end
        checks++;
        if (tot_fw !== 8) begin
            failures++; $display("FAIL b2b_fw_tready_count got=%0d required=8", tot_fw);
        end
        checks++;
        if (tot_run !== 8) begin
            failures++; $display("FAIL b2b_runcmd_tready_count got=%0d required=8", tot_run);
        end
        checks++;
        if (tot_trig !== 8) begin
            failures++; $display("FAIL b2b_trig_tready_count got=%0d required=8", tot_trig);
        end
    endtask

    task automatic test_reset_midframe();
        // Word with bit 19 set, so cmd_o is high at count 12 of its frame.
        drive_frame(1'b0, 8'h00, 2'b00, 1'b0, 2'b00, 1'b1, 15'h7FFF,
                    exp_word(2'(next_frame), 1'b0, 2'b00, 1'b1, 15'h7FFF, 1'b0, 8'h00, 2'b00));
        repeat (12) @(posedge sysclk_i);
        @(negedge sysclk_i);
        checks++;
        if (cmd_o !== 1'b1) begin
            failures++; $display("FAIL pre_reset_bit19 got=%b required=1", cmd_o);
        end
        #2 sysclk_rstn_i = 1'b0;
        #1;
        checks++;
        if ({fw_tready, runcmd_tready, trig_tready, fw_marked_o, cmd_o, cmd_frame_o} !== 6'b0) begin
            failures++;
            $display("FAIL async_reset_outputs got=%b required=000000",
                     {fw_tready, runcmd_tready, trig_tready, fw_marked_o, cmd_o, cmd_frame_o});
        end
        exp_q.delete();
        repeat (2) @(negedge sysclk_i);
        release_reset();
        drive_frame(1'b0, 8'h00, 2'b00, 1'b0, 2'b00, 1'b0, 15'h0, 32'h0000_0100);
    endtask

    task automatic test_drain();
        repeat (34) @(negedge sysclk_i);
        checks++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL drain_pending got=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        sysclk_rstn_i = 1'b0;
        fw_tdata = '0; fw_tvalid = 1'b0; fw_mark_i = '0;
        runcmd_tdata = '0; runcmd_tvalid = 1'b0;
        trig_tdata = '0; trig_tvalid = 1'b0;
        test_reset();
        test_runcmd();
        test_trig();
        test_fw_mark();
        test_back_to_back();
        test_reset_midframe();
        test_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/surfturf_cmd_serializer.md
# surfturf_cmd_serializer

Sysclk-domain consumer of the SURF-link command streams (fwupdate bytes, firmware marks, run commands, triggers) produced by the TURFIO register core. Once per 32-cycle frame it merges at most one item from each stream into a 32-bit command word with odd parity. It shifts that word out MSB-first on a single serial line toward the SURF command output stage. It is the transmit end of the fw/mark/runcmd/trig interface.

## Interface
- `FRAME_BITS`, default 32: frame length in sysclk cycles. Fixed at 32; other values are not supported.
- `sysclk_i`  in  1: system clock; the only clock.
- `sysclk_rstn_i`  in  1: reset. Asynchronous assert, active-low.
- `fw_tdata`  in  8: fwupdate byte.
- `fw_tvalid`  in  1: fwupdate byte valid.
- `fw_tready`  out  1: one-cycle pulse per frame.
- `fw_mark_i`  in  2: pending firmware mark requests (levels).
- `fw_marked_o`  out  1: one-cycle pulse when the marks are sent.
- `runcmd_tdata`  in  `RACKBUS_RUNCMD_BITS` (2): run command.
- `runcmd_tvalid`  in  1: run command valid.
- `runcmd_tready`  out  1: one-cycle pulse per frame.
- `trig_tdata`  in  `RACKBUS_TRIG_BITS` (15): trigger.
- `trig_tvalid`  in  1: trigger valid.
- `trig_tready`  out  1: one-cycle pulse per frame.
- `cmd_o`  out  1: serial command bit.
- `cmd_frame_o`  out  1: high while bit 31 of a word is on `cmd_o`.

## Operation
- Word layout:
  - [31] odd parity over [30:0]
  - [30:29] runcmd
  - [28] trig valid
  - [27:13] trig
  - [12] fw valid
  - [11:10] mark
  - [9:8] sequence
  - [7:0] fw byte
- Frame counter `cnt`:
  - Counts 0..31 and wraps 31 to 0.
  - `cnt` == k means bit 31-k of the current word is on `cmd_o`.
- LOAD cycle is `cnt` == 31. In that cycle:
  - All three tready outputs are high for exactly this one cycle.
  - Each stream's tdata/tvalid is sampled at the closing edge.
  - The next word is built and enters the shift register at that edge.
- tready is never held high across more than one cycle. Upstream valid flags clear on any tready, so tready must be a pulse.
- Word assembly:
  - A stream item whose tvalid is low at LOAD contributes zeros, including its valid bit.
  - runcmd 0 is a NOP.
  - Items are consumed only when tvalid and tready are both high.
- Marks:
  - If `fw_mark_i` is nonzero at LOAD, `fw_mark_i` is copied into [11:10].
  - `fw_marked_o` pulses in that same LOAD cycle.
  - Marks are sent whether or not a fw byte is sent.
- Sequence field:
  - 2-bit, increments once per frame, wraps 3 to 0.
  - Reset value 0; the first frame after reset carries seq 0.
- Simultaneous fw byte, mark, runcmd and trig all go out in one frame. No stream ever starves another.

## Timing
- Reset (asynchronous) sets:
  - `cnt`=31, shift register=0, seq=0.
  - All treadys=0, `fw_marked_o`=0, `cmd_o`=0, `cmd_frame_o`=0.
- The first cycle after reset release is LOAD. This holds even if reset is released mid-frame; a partial frame is dropped and never resumed.
- `cmd_o` and `cmd_frame_o` are registered and come directly from the shift register and `cnt`.
- Latency: an item sampled at the LOAD edge has bit 31 on `cmd_o` in the next cycle and bit 0 on `cmd_o` 32 cycles after the LOAD edge.
- Tready and `fw_marked_o` are registered, decoded from `cnt` == 30 in the prior cycle.
- Throughput: at most one item per stream per 32 cycles. The fw stream peaks at 8 bits per frame.
- Parity is computed combinationally from the assembled [30:0] and registered together with the word.

## Structure
- Word field offsets and widths go in `rackbus.vh`, next to `RACKBUS_RUNCMD_BITS` and `RACKBUS_TRIG_BITS`:
  - `RACKBUS_CMD_PARITY`, `_RUNCMD_LSB`, `_TRIGV`, `_TRIG_LSB`, `_FWV`, `_MARK_LSB`, `_SEQ_LSB`.
- A SURF-side decoder shares these defines.
- No sub-module: the counter, assembler and shift register stay in one module. Parity is a reduction XOR.

## Test plan
- Reset release with no stimulus:
  - Frame 0 is 0x80000000 and frame 1 is 0x00000100.
  - `cmd_frame_o` is high on every 32nd cycle.
- runcmd=2'b10 held valid before the frame-2 LOAD:
  - Frame 2 is 0xC0000200.
  - `runcmd_tready` pulses exactly once, in the LOAD cycle.
- trig=15'h1234 valid in a seq-0 frame: word is 0x92468000.
- fw byte 0xA5 valid with `fw_mark_i`=2'b01 in a seq-3 frame:
  - Word is 0x800017A5.
  - `fw_marked_o` and `fw_tready` pulse together.
- Four streams continuously valid for 8 frames:
  - Exactly 8 treadys per stream.
  - Seq runs 0,1,2,3,0,...
  - Every word has odd parity.
- Reset asserted at `cnt`=12:
  - All outputs go to 0 immediately.
  - After release, LOAD occurs in the first cycle and seq restarts at 0.
